// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
//   loader_state_e : loader FSM states
//   HDR_BYTES      : header length in bytes (16-bit little-endian word count)
//   WORD_BYTES     : bytes per instruction word
package imem_loader_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 8 * HDR_BYTES;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_LOAD   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_e;

    // True while a load session is consuming bytes.
    function automatic logic in_session(input loader_state_e s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
//   clk, rst_n    : clock, async active-low reset
//   clear_i       : restart at byte lane 0 (new session)
//   byte_valid_i  : byte_i is consumed this cycle
//   byte_i        : incoming byte
//   lane_o        : lane the next consumed byte lands in
//   word_valid_o  : one-cycle pulse, the cycle after a word's last byte
//   word_o        : last completed word (held between pulses)
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [LANE_W-1:0] lane_o,
    output logic              word_valid_o,
    output logic [31:0]       word_o
);
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [31:0]       word_q, word_d;
    logic              wv_q, wv_d;

    // Bytes enter at the top and shift down, so the first byte ends in bits 7:0.
    always_comb begin
        lane_d  = lane_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        wv_d    = 1'b0;
        if (clear_i) begin
            lane_d  = '0;
            shreg_d = '0;
        end else if (byte_valid_i) begin
            shreg_d = {byte_i, shreg_q[31:8]};
            lane_d  = lane_q + LANE_W'(1);
            if (lane_q == LANE_W'(WORD_BYTES - 1)) begin
                word_d = shreg_d;
                wv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            wv_q    <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            wv_q    <= wv_d;
        end
    end

    assign lane_o       = lane_q;
    assign word_valid_o = wv_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction memory while holding
// the core in reset. Stream: 16-bit LE word count, then count*4 data bytes.
//   clk, reset           : clock, async active-low reset
//   start                : begin a session (ignored while busy)
//   rx_data/valid/ready  : byte stream handshake
//   mem_we/addr/wdata    : instruction memory write port
//   busy, done, err      : session status; core_hold = ~done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        core_hold
);
    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  widx_q, widx_d;
    logic [CNT_W-1:0]  hdr_c;
    logic [31:0]       addr_q, addr_d;
    logic              rx_ready_q, busy_q, done_q, err_q, hold_q;
    logic              accept_c, clear_c, pk_valid_c, word_last_c;
    logic [LANE_W-1:0] lane;

    assign accept_c    = rx_valid & rx_ready_q;
    assign clear_c     = start & ~in_session(state_q);
    assign pk_valid_c  = accept_c & (state_q == ST_LOAD);
    assign word_last_c = pk_valid_c & (lane == LANE_W'(WORD_BYTES - 1));
    assign hdr_c       = {rx_data, count_q[7:0]};

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (clear_c),
        .byte_valid_i (pk_valid_c),
        .byte_i       (rx_data),
        .lane_o       (lane),
        .word_valid_o (mem_we),
        .word_o       (mem_wdata)
    );

    // Session sequencing; address is latched with the word so it lines up with mem_we.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_LO;
                    count_d = '0;
                    widx_d  = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_HDR_LO: begin
                if (accept_c) begin
                    count_d[7:0] = rx_data;
                    state_d      = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept_c) begin
                    count_d = hdr_c;
                    if (hdr_c == '0) begin
                        state_d = ST_DONE;
                    end else if (32'(hdr_c) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_last_c) begin
                    addr_d = BASE_ADDR + (32'(widx_q) << 2);
                    widx_d = widx_q + CNT_W'(1);
                    if (widx_q == count_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are derived from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            widx_q     <= '0;
            addr_q     <= BASE_ADDR;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            addr_q     <= addr_d;
            rx_ready_q <= in_session(state_d);
            busy_q     <= in_session(state_d);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
            hold_q     <= (state_d != ST_DONE);
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign core_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed sequences, a vector table of
// header cases with random payloads, and a cycle monitor that predicts every
// write from the accepted byte stream.
module tb_imem_loader;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err, core_hold;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_hold (core_hold)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0] cnt;
        logic        gap;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: from bytes actually accepted, predict when a write must appear.
    int          sess_idx = 0;
    int          d_idx;
    logic [15:0] sess_cnt = '0;
    logic        exp_we_nxt = 1'b0;
    wr_t         mw;

    always @(negedge clk) begin
        if (!reset) begin
            sess_idx   = 0;
            sess_cnt   = '0;
            exp_we_nxt = 1'b0;
            if (mem_we) check("we_in_reset", 32'(mem_we), 32'd0);
        end else begin
            if (mem_we || exp_we_nxt)
                check("we_timing", 32'(mem_we), 32'(exp_we_nxt));
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_write: got write addr %h data %h, expected none", mem_addr, mem_wdata);
                end else begin
                    mw = exp_q.pop_front();
                    check("wr_addr", mem_addr, mw.addr);
                    check("wr_data", mem_wdata, mw.data);
                    check("done_with_write", 32'(done), 32'(mw.last));
                end
            end
            exp_we_nxt = 1'b0;
            if (start && !busy) begin
                sess_idx = 0;
                sess_cnt = '0;
            end else if (rx_valid && rx_ready) begin
                if (sess_idx == 0) begin
                    sess_cnt[7:0] = rx_data;
                end else if (sess_idx == 1) begin
                    sess_cnt[15:8] = rx_data;
                end else begin
                    d_idx = sess_idx - 2;
                    if ((d_idx % 4) == 3 && (d_idx / 4) < int'(sess_cnt) && int'(sess_cnt) <= int'(DEPTH))
                        exp_we_nxt = 1'b1;
                end
                sess_idx++;
            end
        end
    end

    // Reference: the written image is simply the payload read 4 bytes at a time, LE.
    task automatic model_load(input logic [15:0] cnt, input logic [7:0] data[$]);
        if (cnt != 16'd0 && int'(cnt) <= int'(DEPTH)) begin
            for (int k = 0; k < int'(cnt); k++) begin
                wr_t w;
                w.addr = 32'(4 * k);
                w.data = {data[4*k+3], data[4*k+2], data[4*k+1], data[4*k]};
                w.last = (k == int'(cnt) - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic gap);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        if (gap) cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_clr", 32'(err), 32'd0);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic load_fixed(input logic gap);
        logic [7:0] b[10];
        wr_t w;
        b = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40};
        do_start();
        w.addr = 32'h0; w.data = 32'h0011_0233; w.last = 1'b0; exp_q.push_back(w);
        w.addr = 32'h4; w.data = 32'h4011_02B3; w.last = 1'b1; exp_q.push_back(w);
        for (int i = 0; i < 10; i++) send(b[i], gap);
        cyc();
        check("fixed_done", 32'(done), 32'd1);
        check("fixed_hold", 32'(core_hold), 32'd0);
        check("fixed_ready", 32'(rx_ready), 32'd0);
        check("fixed_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] data[$];
        int         nbytes;
        logic       ok_cnt;
        ok_cnt = (v.cnt != 16'd0) && (int'(v.cnt) <= int'(DEPTH));
        do_start();
        send(v.cnt[7:0], v.gap);
        send(v.cnt[15:8], v.gap);
        check("hdr_done", 32'(done), 32'(v.cnt == 16'd0));
        check("hdr_err", 32'(err), 32'(int'(v.cnt) > int'(DEPTH)));
        check("hdr_ready", 32'(rx_ready), 32'(ok_cnt));
        nbytes = ok_cnt ? 4 * int'(v.cnt) : 8;
        for (int i = 0; i < nbytes; i++) data.push_back(8'($urandom));
        model_load(v.cnt, data);
        for (int i = 0; i < nbytes; i++) send(data[i], v.gap);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        repeat (3) cyc();
        check("vec_done", 32'(done), 32'(v.exp_done));
        check("vec_err", 32'(err), 32'(v.exp_err));
        check("vec_hold", 32'(core_hold), 32'(!v.exp_done));
        check("vec_busy", 32'(busy), 32'd0);
        check("vec_ready", 32'(rx_ready), 32'd0);
        check("vec_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_hold"}, 32'(core_hold), 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{16'd2,      1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'd2,      1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'd0,      1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'd65,     1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'd64,     1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'd1,      1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'd5,      1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF,   1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'h0100,   1'b0, 1'b0, 1'b1};
        vecs[9] = '{16'd7,      1'b1, 1'b1, 1'b0};

        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) cyc();
        check_reset_vals("rst");
        reset = 1'b1;
        // Bytes offered while idle must not be taken.
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        cyc();
        check("idle_ready", 32'(rx_ready), 32'd0);
        check("idle_hold", 32'(core_hold), 32'd1);

        load_fixed(1'b0);
        load_fixed(1'b1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Abort mid-word: no partial write, outputs return to reset values at once.
        do_start();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check("post_abort_we", 32'(mem_we), 32'd0);
        check("post_abort_drained", 32'(exp_q.size()), 32'd0);
        load_fixed(1'b0);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port rx_data  input  8  incoming program byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port mem_addr  output  32  word-aligned byte address, same addressing as the fetch port (word index = addr[31:2]).
REQ-011 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-012 SHALL have ports busy, done, err, core_hold  output  1 each  status; core_hold holds the CPU in reset.

Function
REQ-013 SHALL accept a byte only on a cycle with rx_valid=1 and rx_ready=1.
REQ-014 SHALL implement states IDLE, HDR_LO, HDR_HI, LOAD, DONE, ERR.
REQ-015 IDLE/DONE/ERR + start=1 SHALL go to HDR_LO and clear the byte counter, word counter, done and err.
REQ-016 start SHALL be ignored in HDR_LO, HDR_HI and LOAD.
REQ-017 HDR_LO SHALL capture the accepted byte as count[7:0] and go to HDR_HI; HDR_HI SHALL capture count[15:8].
REQ-018 On the HDR_HI accept: count=0 -> DONE; count>DEPTH -> ERR; otherwise -> LOAD.
REQ-019 LOAD SHALL pack bytes little-endian: first byte -> bits 7:0, fourth byte -> bits 31:24.
REQ-020 mem_we SHALL pulse for exactly one cycle, the cycle after the fourth byte of a word is accepted, with mem_addr = BASE_ADDR + 4*k for word index k and mem_wdata the packed word.
REQ-021 rx_ready SHALL be 1 in HDR_LO, HDR_HI and LOAD, and 0 in IDLE, DONE and ERR; no bubble SHALL be inserted between words.
REQ-022 On the accept of the last byte of word count-1, the FSM SHALL go to DONE; done SHALL rise in the same cycle as the final mem_we.
REQ-023 busy SHALL be 1 in HDR_LO, HDR_HI and LOAD; err SHALL be 1 only in ERR; core_hold SHALL be ~done.
REQ-024 In ERR, bytes SHALL NOT be accepted and mem_we SHALL stay 0; err SHALL remain set until start or reset.
REQ-025 Word index k SHALL never exceed DEPTH-1; mem_addr SHALL not wrap.
REQ-026 Bytes presented in IDLE, DONE or ERR SHALL be ignored and not stored.

Reset
REQ-027 Asserting reset SHALL asynchronously force IDLE, with all counters 0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, rx_ready=0, busy=0, done=0, err=0, core_hold=1.
REQ-028 Reset during LOAD SHALL abort the session; a partially assembled word SHALL never be written.
REQ-029 Reset deassertion SHALL take effect on the next clk edge with no spurious mem_we.

Structure
REQ-030 A shared package imem_loader_pkg SHALL hold the state enum, HDR_BYTES=2 and WORD_BYTES=4.
REQ-031 Byte-to-word packing (byte lane counter plus 32-bit shift register with a word_valid pulse) SHALL be a single sub-module, imem_word_packer.
REQ-032 The FSM, count register and address counter SHALL live in imem_loader.

Verification
REQ-033 Load 2 words:
- Stimulus: start; bytes 02 00 33 02 11 00 B3 02 11 40.
- Response: mem_we at addr 0x0 data 0x00110233, then at addr 0x4 data 0x401102B3; done=1 with the second mem_we; core_hold drops.
REQ-034 count=0:
- Stimulus: start; bytes 00 00.
- Response: DONE on the cycle after the HDR_HI accept; no mem_we; rx_ready=0.
REQ-035 Overflow:
- Stimulus: DEPTH=64; start; bytes 41 00 (count 65).
- Response: err=1, rx_ready=0; subsequent bytes produce no mem_we; a new start clears err.
REQ-036 Backpressure gaps:
- Stimulus: rx_valid toggled 1/0 every cycle during the 2-word load of REQ-033.
- Response: identical writes; each mem_we exactly one cycle after the 4th accepted byte.
REQ-037 Reset mid-load:
- Stimulus: reset asserted after 2 bytes of word 1.
- Response: immediate IDLE, outputs at reset values, no mem_we; a fresh load then writes word 0 at 0x0.
REQ-038 Full depth:
- Stimulus: DEPTH=64; count 64 (bytes 40 00), 256 data bytes.
- Response: last write at addr 0xFC; done=1; further bytes ignored.
